// File: rtl/btb_pkg.sv
// Shared types and helpers for the branch target buffer.
package btb_pkg;

  typedef enum logic [1:0] {SNT, WNT, WT, ST} pred_t;

  // Tags are stored zero-extended to 30 bits so the struct does not depend on ENTRIES.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [31:0] target;
    pred_t       pred;
  } btb_entry_t;

  localparam pred_t PRED_RESET = WNT;
  localparam pred_t PRED_ALLOC = WT;

  function automatic logic [1:0] sat_inc(input logic [1:0] p);
    return (p == 2'b11) ? 2'b11 : p + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] p);
    return (p == 2'b00) ? 2'b00 : p - 2'b01;
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating counter next-state from current prediction and resolved outcome.
module btb_sat_counter
  import btb_pkg::*;
(
  input  logic [1:0] pred_i,
  input  logic       taken_i,
  output logic [1:0] pred_o
);

  always_comb begin
    pred_o = taken_i ? sat_inc(pred_i) : sat_dec(pred_i);
  end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit counters; combinational fetch lookup, execute-stage update.
// Optional same-cycle write-to-read forwarding enabled by defining BTB_FWD_EN.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] pcf_i,
  output logic        hitF_o,
  output logic [1:0]  prediccionF_o,
  output logic        selbpF_o,
  output logic [31:0] pc_targetF_o,
  input  logic        update_i,
  input  logic [31:0] pce_i,
  input  logic        takene_i,
  input  logic [31:0] targete_i
);

  localparam int unsigned INDEX_W = $clog2(ENTRIES);

  btb_entry_t table_q [ENTRIES];
  btb_entry_t table_d [ENTRIES];

  logic [INDEX_W-1:0] idx_e, idx_f;
  logic [29:0]        tag_e, tag_f;
  btb_entry_t         rd_e, rd_f, upd_entry;
  logic               hit_e, we;
  logic [1:0]         pred_nxt;
  logic               unused_pc_bits;

  assign unused_pc_bits = ^{pce_i[1:0], pcf_i[1:0]};

  assign idx_e = pce_i[INDEX_W+1:2];
  assign idx_f = pcf_i[INDEX_W+1:2];
  assign tag_e = pce_i[31:2] >> INDEX_W;
  assign tag_f = pcf_i[31:2] >> INDEX_W;

  assign rd_e  = table_q[idx_e];
  assign hit_e = rd_e.valid && (rd_e.tag == tag_e);

  btb_sat_counter u_sat_counter (
    .pred_i  (rd_e.pred),
    .taken_i (takene_i),
    .pred_o  (pred_nxt)
  );

  // Tag is re-checked here rather than trusting the pipelined hit flag.
  always_comb begin
    upd_entry = rd_e;
    we        = 1'b0;
    if (update_i) begin
      if (hit_e) begin
        we             = 1'b1;
        upd_entry.pred = pred_t'(pred_nxt);
        if (takene_i) upd_entry.target = targete_i;
      end else if (takene_i) begin
        we               = 1'b1;
        upd_entry.valid  = 1'b1;
        upd_entry.tag    = tag_e;
        upd_entry.target = targete_i;
        upd_entry.pred   = PRED_ALLOC;
      end
    end
  end

  always_comb begin
    table_d = table_q;
    if (we) table_d[idx_e] = upd_entry;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        table_q[i] <= '{valid: 1'b0, tag: '0, target: '0, pred: PRED_RESET};
      end
    end else begin
      table_q <= table_d;
    end
  end

  always_comb begin
    rd_f = table_q[idx_f];
`ifdef BTB_FWD_EN
    if (we && reset_i && (idx_e == idx_f)) rd_f = upd_entry;
`endif
  end

  always_comb begin
    hitF_o        = rd_f.valid && (rd_f.tag == tag_f);
    prediccionF_o = hitF_o ? rd_f.pred : PRED_RESET;
    selbpF_o      = hitF_o & prediccionF_o[1];
    pc_targetF_o  = hitF_o ? rd_f.target : 32'h0;
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Directed self-checking bench for btb_predictor with a queue-based expected-result scoreboard.
module tb_btb_predictor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pcf_i;
  logic        hitF_o;
  logic [1:0]  prediccionF_o;
  logic        selbpF_o;
  logic [31:0] pc_targetF_o;
  logic        update_i;
  logic [31:0] pce_i;
  logic        takene_i;
  logic [31:0] targete_i;

  typedef struct {
    string       name;
    logic        hit;
    logic [1:0]  pred;
    logic        sel;
    logic [31:0] tgt;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  btb_predictor #(.ENTRIES(16)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .pcf_i         (pcf_i),
    .hitF_o        (hitF_o),
    .prediccionF_o (prediccionF_o),
    .selbpF_o      (selbpF_o),
    .pc_targetF_o  (pc_targetF_o),
    .update_i      (update_i),
    .pce_i         (pce_i),
    .takene_i      (takene_i),
    .targete_i     (targete_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic expect_lookup(input string name, input logic hit, input logic [1:0] pred,
                               input logic [31:0] tgt);
    exp_t e;
    e.name = name;
    e.hit  = hit;
    e.pred = pred;
    e.sel  = hit & pred[1];
    e.tgt  = tgt;
    exp_q.push_back(e);
  endtask

  // Pops the oldest expectation and compares it against the current lookup outputs.
  task automatic check_lookup();
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = exp_q.pop_front();
    checks++;
    assert (hitF_o === e.hit) else begin
      errors++;
      $error("FAIL %s.hit observed=%0b expected=%0b", e.name, hitF_o, e.hit);
    end
    checks++;
    assert (prediccionF_o === e.pred) else begin
      errors++;
      $error("FAIL %s.pred observed=%02b expected=%02b", e.name, prediccionF_o, e.pred);
    end
    checks++;
    assert (selbpF_o === e.sel) else begin
      errors++;
      $error("FAIL %s.selbp observed=%0b expected=%0b", e.name, selbpF_o, e.sel);
    end
    checks++;
    assert (pc_targetF_o === e.tgt) else begin
      errors++;
      $error("FAIL %s.target observed=%h expected=%h", e.name, pc_targetF_o, e.tgt);
    end
  endtask

  task automatic lookup(input string name, input logic [31:0] pc, input logic hit,
                        input logic [1:0] pred, input logic [31:0] tgt);
    pcf_i = pc;
    expect_lookup(name, hit, pred, tgt);
    check_lookup();
  endtask

  task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    update_i  = 1'b1;
    pce_i     = pc;
    takene_i  = taken;
    targete_i = tgt;
    tick();
    update_i  = 1'b0;
  endtask

  initial begin
    reset_i   = 1'b0;
    pcf_i     = 32'h0;
    update_i  = 1'b0;
    pce_i     = 32'h0;
    takene_i  = 1'b0;
    targete_i = 32'h0;
    tick();
    tick();
    reset_i = 1'b1;

    lookup("reset_0x40", 32'h40, 1'b0, 2'b01, 32'h0);

    update(32'h40, 1'b1, 32'h100);
    lookup("alloc_0x40", 32'h40, 1'b1, 2'b10, 32'h100);

    update(32'h40, 1'b1, 32'h100);
    lookup("inc_to_11", 32'h40, 1'b1, 2'b11, 32'h100);
    update(32'h40, 1'b1, 32'h104);
    lookup("sat_11_newtgt", 32'h40, 1'b1, 2'b11, 32'h104);

    update(32'h40, 1'b0, 32'hdead);
    lookup("dec_to_10", 32'h40, 1'b1, 2'b10, 32'h104);
    update(32'h40, 1'b0, 32'hdead);
    lookup("dec_to_01", 32'h40, 1'b1, 2'b01, 32'h104);
    update(32'h40, 1'b0, 32'hdead);
    lookup("dec_to_00", 32'h40, 1'b1, 2'b00, 32'h104);
    update(32'h40, 1'b0, 32'hdead);
    lookup("sat_00", 32'h40, 1'b1, 2'b00, 32'h104);

    lookup("alias_miss_0x440", 32'h440, 1'b0, 2'b01, 32'h0);
    update(32'h440, 1'b1, 32'h200);
    lookup("alias_hit_0x440", 32'h440, 1'b1, 2'b10, 32'h200);
    lookup("alias_evict_0x40", 32'h40, 1'b0, 2'b01, 32'h0);

    update(32'h80, 1'b0, 32'h300);
    lookup("nt_miss_0x80", 32'h80, 1'b0, 2'b01, 32'h0);
    lookup("nt_miss_keep_0x440", 32'h440, 1'b1, 2'b10, 32'h200);

    reset_i = 1'b0;
    update(32'h40, 1'b1, 32'h100);
    reset_i = 1'b1;
    lookup("rst_mid_0x40", 32'h40, 1'b0, 2'b01, 32'h0);
    lookup("rst_mid_0x440", 32'h440, 1'b0, 2'b01, 32'h0);

    // Same-cycle update and lookup on an empty table.
    update_i  = 1'b1;
    pce_i     = 32'h40;
    takene_i  = 1'b1;
    targete_i = 32'h100;
    pcf_i     = 32'h40;
`ifdef BTB_FWD_EN
    expect_lookup("same_cycle_alloc", 1'b1, 2'b10, 32'h100);
`else
    expect_lookup("same_cycle_alloc", 1'b0, 2'b01, 32'h0);
`endif
    check_lookup();
    tick();
    update_i = 1'b0;
    lookup("next_cycle_alloc", 32'h40, 1'b1, 2'b10, 32'h100);

    // Same-cycle not-taken on a hitting entry.
    update_i  = 1'b1;
    pce_i     = 32'h40;
    takene_i  = 1'b0;
    targete_i = 32'h999;
`ifdef BTB_FWD_EN
    expect_lookup("same_cycle_dec", 1'b1, 2'b01, 32'h100);
`else
    expect_lookup("same_cycle_dec", 1'b1, 2'b10, 32'h100);
`endif
    check_lookup();
    tick();
    update_i = 1'b0;
    lookup("next_cycle_dec", 32'h40, 1'b1, 2'b01, 32'h100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
